// File: rtl/instruction_fetch.sv
// Fetch stage: PC register, word-addressed instruction memory with a load port,
// next-PC selection and a run/stall/halt controller with retire counting.
module instruction_fetch #(
  parameter int          IMEM_DEPTH = 256,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          imem_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
  input  logic [31:0]                   imem_wdata,
  input  logic                          stall,
  input  logic [1:0]                    pc_sel,
  input  logic [31:0]                   branch_offset,
  input  logic [31:0]                   jump_target,
  output logic [31:0]                   pc,
  output logic [31:0]                   instr,
  output logic [20:0]                   imm,
  output logic                          insmsb,
  output logic                          halted,
  output logic                          fault,
  output logic [31:0]                   retired
);

  localparam int AW = $clog2(IMEM_DEPTH);

  localparam logic [1:0] ST_RUN   = 2'b00;
  localparam logic [1:0] ST_STALL = 2'b01;
  localparam logic [1:0] ST_HALT  = 2'b10;

  logic [31:0]   mem [IMEM_DEPTH];
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   retired_q, retired_d;
  logic [1:0]    state_q, state_d;
  logic          fault_q, fault_d;
  logic          in_range;
  logic [AW-1:0] widx;
  logic [31:0]   pc_seq, pc_branch, pc_jump;
  logic          jump_misaligned;

  // Memory contents survive reset; the load port works in every state.
  always_ff @(posedge clk) begin
    if (imem_we) mem[imem_waddr] <= imem_wdata;
  end

  always_comb begin
    widx     = pc_q[AW+1:2];
    in_range = (pc_q[31:AW+2] == '0);
    instr    = in_range ? mem[widx] : 32'h0000_0000;
  end

  always_comb begin
    pc_seq          = pc_q + 32'd4;
    pc_branch       = pc_seq + (branch_offset << 2);
    pc_jump         = jump_target & 32'hFFFF_FFFC;
    jump_misaligned = (jump_target[1:0] != 2'b00);
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    retired_d = retired_q;
    fault_d   = fault_q;
    case (state_q)
      ST_HALT: begin
        state_d = ST_HALT;
      end
      ST_STALL: begin
        if (!in_range) fault_d = 1'b1;
        // Leaving stall only re-enters RUN; the held fetch acts on the next edge.
        if (!stall) state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
        if (!in_range) fault_d = 1'b1;
        if (stall) begin
          state_d = ST_STALL;
        end else if (instr == HALT_WORD) begin
          state_d = ST_HALT;
        end else begin
          retired_d = retired_q + 32'd1;
          case (pc_sel)
            2'b01: pc_d = pc_branch;
            2'b10: begin
              pc_d = pc_jump;
              if (jump_misaligned) fault_d = 1'b1;
            end
            default: pc_d = pc_seq;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q      <= RESET_PC;
      state_q   <= ST_RUN;
      fault_q   <= 1'b0;
      retired_q <= 32'd0;
    end else begin
      pc_q      <= pc_d;
      state_q   <= state_d;
      fault_q   <= fault_d;
      retired_q <= retired_d;
    end
  end

  assign pc      = pc_q;
  assign imm     = instr[20:0];
  assign insmsb  = instr[31];
  assign halted  = (state_q == ST_HALT);
  assign fault   = fault_q;
  assign retired = retired_q;

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch stage of the single-cycle processor; sits directly upstream of the sign-extension unit.
- Holds the PC and a word-addressed instruction memory, and computes next-PC (sequential, PC-relative branch, register jump).
- Presents the current instruction and its split fields: imm[20:0] and insmsb feed the sign extender; its 32-bit result returns as branch_offset.
- Adds a run/stall/halt state machine and a bench load port.

Parameters:
- IMEM_DEPTH, 256, number of 32-bit instruction words (power of two).
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- HALT_WORD, 32'hFFFF_FFFF, instruction encoding that halts fetch.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_we  in  1  write enable for the instruction-memory load port.
- imem_waddr  in  log2(IMEM_DEPTH)  word address for load.
- imem_wdata  in  32  word to load.
- stall  in  1  hold PC this cycle.
- pc_sel  in  2  00 = sequential, 01 = branch, 10 = jump register, 11 = reserved (treated as 00).
- branch_offset  in  32  sign-extended offset from the sign extender, in words.
- jump_target  in  32  byte address for a register jump.
- pc  out  32  current PC.
- instr  out  32  instruction at pc.
- imm  out  21  instr[20:0], to the sign extender.
- insmsb  out  1  instr[31], to the sign extender.
- halted  out  1  high in HALT.
- fault  out  1  sticky: misaligned target or out-of-range fetch.
- retired  out  32  count of instructions retired since reset.

Behaviour:
- Reset (synchronous, highest priority):
  - pc = RESET_PC, state = RUN, halted = 0, fault = 0, retired = 0.
  - Memory contents are not cleared.
- Memory:
  - Write: synchronous; on imem_we, mem[imem_waddr] = imem_wdata at the clock edge. Writes are accepted in every state, including during reset.
  - Read: combinational. instr = mem[pc[log2(IMEM_DEPTH)+1:2]] when the word index is < IMEM_DEPTH and pc[31:2+log2(IMEM_DEPTH)] == 0.
  - Otherwise instr = 32'h0000_0000 (NOP) and fault is set at the next edge.
- imm and insmsb: pure slices of instr, no latency.
- States: RUN, STALL, HALT.
  - RUN: if stall, go to STALL and hold pc. Else if instr == HALT_WORD, go to HALT and hold pc. Else update pc per pc_sel and increment retired.
  - STALL: hold pc and retired. When stall deasserts, return to RUN; that cycle's fetch is the held instruction, with no new edge effect until the following cycle.
  - HALT: hold everything; halted = 1. Exit only via reset; stall and pc_sel are ignored.
- Next-PC arithmetic (32-bit, modulo 2^32, wrap-around silent):
  - seq: pc + 4.
  - branch: pc + 4 + (branch_offset << 2).
  - jump: {jump_target[31:2], 2'b00}. If jump_target[1:0] != 0, set fault and still take the aligned target.
- Priority in RUN: reset > stall > halt detection > pc_sel. If stall and HALT_WORD occur together, STALL wins; halt is taken after stall releases.
- Fault is sticky until reset; it never stops fetch.
- retired wraps from 32'hFFFF_FFFF to 0.
- Reset mid-stall or mid-halt: the next edge gives the reset values above.

Test Plan:
- Load words 0..3 = 32'h0012_3456, 32'h8001_2FF5, 32'h0000_0001, HALT_WORD; reset; run → pc sequence 0, 4, 8, 12. imm/insmsb at pc=4 are 21'h012FF5 / 1. HALT is entered at pc=12 with halted=1, retired=3, and pc stays 12 for 10 more cycles.
- At pc=8, pc_sel=01 with branch_offset=32'hFFFF_FFFD (-3) → next pc = 8 + 4 - 12 = 0; retired increments.
- pc_sel=10, jump_target=32'h0000_0012 → pc = 32'h10, fault = 1 and stays 1 through subsequent fetches until reset.
- Assert stall for 3 cycles at pc=4 → pc holds 4 and retired holds. On release, pc = 8 one cycle after the first non-stall cycle. Stall coincident with HALT_WORD → no halt until stall drops.
- Jump to 32'h0000_0400 with IMEM_DEPTH=256 → instr = 0, fault = 1 next edge, pc advances to 32'h404.
- Assert reset while in HALT and while stalled → next edge gives pc = RESET_PC, halted = 0, fault = 0, retired = 0, and memory contents are preserved.
